// File: rtl/bht_update_controller.sv
// bht_update_controller: 2-bit counter branch history table with an initialisation sweep and a queued read-modify-write update path
module bht_update_controller #(
  parameter int INDEX_BITS = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   lookup_pc,
  output logic                          lookup_taken,
  input  logic                          upd_valid,
  input  logic [31:0]                   upd_pc,
  input  logic                          upd_taken,
  output logic                          upd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          init_done
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic init_done_q, init_done_d;
  logic [INDEX_BITS-1:0] rd_idx_q, rd_idx_d;
  logic rd_dir_q, rd_dir_d;
  logic [1:0] rd_ctr_q, rd_ctr_d;
  logic [1:0] tbl [ENTRIES];
  logic [INDEX_BITS-1:0] fifo_idx [FIFO_DEPTH];
  logic fifo_dir [FIFO_DEPTH];
  logic [INDEX_BITS-1:0] lk_idx, up_idx, tbl_wa;
  logic [1:0] tbl_wd, sat;
  logic push, pop, tbl_we;
  logic unused_pc_bits;
  assign lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign up_idx = upd_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0], upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};
  assign upd_ready = init_done_q && (count_q < CW'(FIFO_DEPTH));
  assign push = upd_valid && upd_ready;
  assign pop = state_q == WRITE;
  assign fifo_count = count_q;
  assign init_done = init_done_q;
  assign lookup_taken = init_done_q && tbl[lk_idx][1];
  assign sat = rd_dir_q ? (rd_ctr_q == 2'b11 ? 2'b11 : rd_ctr_q + 2'b01)
                        : (rd_ctr_q == 2'b00 ? 2'b00 : rd_ctr_q - 2'b01);
  assign tbl_we = (state_q == INIT) || (state_q == WRITE);
  assign tbl_wa = state_q == INIT ? init_idx_q : rd_idx_q;
  assign tbl_wd = state_q == INIT ? 2'b01 : sat;
  // next-state: init sweep, queue pointer/occupancy bookkeeping and the read-then-write update sequence
  always_comb begin
    state_d = state_q;
    init_idx_d = init_idx_q;
    init_done_d = init_done_q;
    head_d = head_q;
    rd_idx_d = rd_idx_q;
    rd_dir_d = rd_dir_q;
    rd_ctr_d = rd_ctr_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + INDEX_BITS'(1);
        if (init_idx_q == INDEX_BITS'(ENTRIES - 1)) begin
          state_d = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: state_d = count_q != '0 ? READ : IDLE;
      READ: begin
        rd_idx_d = fifo_idx[head_q];
        rd_dir_d = fifo_dir[head_q];
        rd_ctr_d = tbl[fifo_idx[head_q]];
        state_d = WRITE;
      end
      WRITE: begin
        head_d = head_q + PW'(1);
        state_d = count_q > CW'(1) ? READ : IDLE;
      end
      default: state_d = INIT;
    endcase
  end
  // control state with asynchronous reset; reset restarts the sweep and empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      init_idx_q <= '0;
      init_done_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      rd_idx_q <= '0;
      rd_dir_q <= 1'b0;
      rd_ctr_q <= '0;
    end else begin
      state_q <= state_d;
      init_idx_q <= init_idx_d;
      init_done_q <= init_done_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      rd_idx_q <= rd_idx_d;
      rd_dir_q <= rd_dir_d;
      rd_ctr_q <= rd_ctr_d;
    end
  end
  // queue storage is not reset; only entries between head and tail are meaningful
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[tail_q] <= up_idx;
      fifo_dir[tail_q] <= upd_taken;
    end
  end
  // counter table is only defined by the init sweep and later written back by WRITE
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_wa] <= tbl_wd;
  end
endmodule

// File: tb/tb_bht_update_controller.sv
// tb_bht_update_controller: randomized and directed checks of the BHT update controller against a schedule-based model
module tb_bht_update_controller;
  localparam int IB = 6;
  localparam int N = 1 << IB;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic lookup_taken;
  logic upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic upd_taken = 1'b0;
  logic upd_ready;
  logic [2:0] fifo_count;
  logic init_done;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {int idx; bit tk; int t;} ent_t;
  ent_t q[$];
  int mtbl [N];
  int edge_n = 0;
  int edges_since = 0;
  int last_t = -10;
  typedef struct {logic [31:0] pc; bit taken; bit exp_lk;} vec_t;
  vec_t v [5];
  bht_update_controller #(.INDEX_BITS(IB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .fifo_count(fifo_count), .init_done(init_done)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  function automatic int idx(logic [31:0] pc);
    return int'((pc >> 2) & (N - 1));
  endfunction
  function automatic bit init_m();
    return edges_since >= N;
  endfunction
  function automatic bit ready_m();
    return init_m() && q.size() < DEPTH;
  endfunction
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_n);
    end
  endtask
  task automatic model_reset();
    q.delete();
    last_t = -10;
    edges_since = 0;
    for (int i = 0; i < N; i++) mtbl[i] = 1;
  endtask
  // one clock: model accepts per its own readiness, updates complete on a fixed schedule
  task automatic step();
    bit push;
    int t;
    push = upd_valid && ready_m();
    @(posedge clk);
    edge_n++;
    edges_since++;
    if (push) begin
      t = (edge_n + 3 > last_t + 2) ? edge_n + 3 : last_t + 2;
      q.push_back('{idx(upd_pc), upd_taken, t});
      last_t = t;
    end
    while (q.size() > 0 && q[0].t == edge_n) begin
      if (q[0].tk) mtbl[q[0].idx] = mtbl[q[0].idx] < 3 ? mtbl[q[0].idx] + 1 : 3;
      else mtbl[q[0].idx] = mtbl[q[0].idx] > 0 ? mtbl[q[0].idx] - 1 : 0;
      void'(q.pop_front());
    end
    #1;
    chk("init_done", int'(init_done), int'(init_m()));
    chk("upd_ready", int'(upd_ready), int'(ready_m()));
    chk("fifo_count", int'(fifo_count), q.size());
    chk("lookup_taken", int'(lookup_taken), init_m() ? int'(mtbl[idx(lookup_pc)] >= 2) : 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    upd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_ready", int'(upd_ready), 0);
    chk("rst_lookup", int'(lookup_taken), 0);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic run_init();
    for (int i = 0; i < N; i++) step();
    chk("init_after_64", int'(init_done), 1);
  endtask
  task automatic drain();
    upd_valid = 1'b0;
    for (int k = 0; k < 200 && q.size() > 0; k++) step();
    step();
    chk("drained", int'(fifo_count), 0);
  endtask
  task automatic all_lookups(string name, int exp);
    for (int i = 0; i < N; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      chk(name, int'(lookup_taken), exp);
    end
  endtask
  initial begin
    int maxc;
    bit acc;
    v[0] = '{32'h40, 1'b1, 1'b1};
    v[1] = '{32'h40, 1'b1, 1'b1};
    v[2] = '{32'h40, 1'b0, 1'b1};
    v[3] = '{32'h40, 1'b0, 1'b0};
    v[4] = '{32'h40, 1'b0, 1'b0};
    model_reset();
    do_reset();
    step();
    chk("init_not_yet", int'(init_done), 0);
    for (int i = 1; i < N; i++) step();
    chk("init_after_64", int'(init_done), 1);
    all_lookups("lookup_after_init", 0);
    lookup_pc = 32'h80;
    upd_pc = 32'h80;
    upd_taken = 1'b1;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    step();
    step();
    chk("no_bypass_write_cycle", int'(lookup_taken), 0);
    step();
    chk("after_write_0x80", int'(lookup_taken), 1);
    lookup_pc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      upd_pc = v[i].pc;
      upd_taken = v[i].taken;
      upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
      repeat (3) step();
      chk($sformatf("seq_0x40_%0d", i), int'(lookup_taken), int'(v[i].exp_lk));
    end
    maxc = 0;
    upd_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      upd_pc = 32'(8 + i) << 2;
      upd_taken = i[0];
      lookup_pc = upd_pc;
      step();
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    chk("max_fill", maxc, DEPTH);
    drain();
    for (int i = 0; i < 400; i++) begin
      upd_valid = $urandom_range(0, 1) == 1;
      upd_pc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 5)) << 2);
      upd_taken = $urandom_range(0, 1) == 1;
      lookup_pc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 5)) << 2);
      step();
    end
    drain();
    upd_taken = 1'b1;
    upd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      upd_pc = 32'(40 + i) << 2;
      step();
    end
    upd_valid = 1'b0;
    chk("pre_reset_count", int'(fifo_count), 3);
    rst = 1'b1;
    #1;
    chk("async_rst_count", int'(fifo_count), 0);
    chk("async_rst_init_done", int'(init_done), 0);
    chk("async_rst_ready", int'(upd_ready), 0);
    chk("async_rst_lookup", int'(lookup_taken), 0);
    do_reset();
    run_init();
    all_lookups("lookup_after_reinit", 0);
    upd_taken = 1'b1;
    for (int i = 0; i < N; i++) begin
      upd_pc = 32'(i) << 2;
      lookup_pc = upd_pc;
      upd_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        acc = ready_m();
        step();
      end
      if (!acc) chk("probe_accept", 0, 1);
    end
    drain();
    all_lookups("probe_counter_01", 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
